// File: rtl/inert_pkg.sv
// Shared types and constants for the inertial calibration monitor.
//   cal_state_t     : calibration FSM states
//   disp_mode_t     : LED display modes selected by the mode input in DISP
//   CAL_PAT_DEFAULT : LED pattern shown while calibration is running
package inert_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        CAL,
        DISP,
        FAIL
    } cal_state_t;

    typedef enum logic [1:0] {
        HEAD,
        HOLD,
        OCT,
        STAT
    } disp_mode_t;

    localparam logic [7:0] CAL_PAT_DEFAULT = 8'hA5;

endpackage

// File: rtl/inert_cal_mon_blink_gen.sv
// Free-running blink prescaler; its MSB is the blink phase.
//   clk   : system clock
//   rst   : asynchronous active-high reset, clears the prescaler
//   blink : prescaler MSB, toggles every 2**(width-1) cycles
module blink_gen #(
    parameter int unsigned BLINK_W  = 22,
    parameter int unsigned FAST_SIM = 0
) (
    input  logic clk,
    input  logic rst,
    output logic blink
);

    // Simulation builds shrink the prescaler so blinking is observable quickly.
    localparam int unsigned PRE_W = (FAST_SIM != 0) ? 4 : BLINK_W;

    logic [PRE_W-1:0] pre_cnt;

    // Prescaler counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    assign blink = pre_cnt[PRE_W-1];

endmodule

// File: rtl/inert_cal_mon.sv
// Calibration sequencer and LED status display for the inertial interface.
// Starts calibration after reset, retries on timeout up to MAX_RETRY times,
// then shows either heading information (DISP) or a blinking failure (FAIL).
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   cal_done  : calibration complete pulse from inert_intf
//   rdy       : heading valid pulse
//   heading   : signed heading from inert_intf
//   recal_req : request to restart calibration (honoured in DISP/FAIL only)
//   mode      : LED display mode select (used in DISP)
//   strt_cal  : one-cycle calibration start pulse (high only in START)
//   cal_ok    : high while in DISP
//   cal_fail  : high while in FAIL
//   LED       : registered display bus
module inert_cal_mon
    import inert_pkg::*;
#(
    parameter int unsigned      FAST_SIM    = 0,
    parameter int unsigned      LED_W       = 8,
    parameter int unsigned      HEAD_W      = 12,
    parameter int unsigned      CAL_TIMEOUT = 65536,
    parameter int unsigned      MAX_RETRY   = 3,
    parameter int unsigned      BLINK_W     = 22,
    parameter logic [LED_W-1:0] CAL_PAT     = LED_W'(CAL_PAT_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cal_done,
    input  logic              rdy,
    input  logic [HEAD_W-1:0] heading,
    input  logic              recal_req,
    input  logic [1:0]        mode,
    output logic              strt_cal,
    output logic              cal_ok,
    output logic              cal_fail,
    output logic [LED_W-1:0]  LED
);

    localparam int unsigned TMO_W   = $clog2(CAL_TIMEOUT);
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    cal_state_t         state, state_nxt;
    logic [TMO_W-1:0]   tmo_cnt, tmo_nxt;
    logic [RETRY_W-1:0] retry_cnt, retry_nxt;
    logic [LED_W-1:0]   hold_reg, hold_nxt;
    logic [LED_W-1:0]   led_nxt;
    logic [LED_W-1:0]   head_top;
    logic [LED_W-1:0]   led_oct;
    logic [2:0]         oct_idx;
    logic               blink;
    logic               heading_unused;

    // Only the top LED_W heading bits are displayed; the rest are intentionally dropped.
    assign heading_unused = ^heading;

    blink_gen #(
        .BLINK_W  (BLINK_W),
        .FAST_SIM (FAST_SIM)
    ) u_blink (
        .clk   (clk),
        .rst   (rst),
        .blink (blink)
    );

    // Next-state, counter and LED selection logic.
    always_comb begin
        state_nxt = state;
        tmo_nxt   = tmo_cnt;
        retry_nxt = retry_cnt;
        hold_nxt  = hold_reg;
        led_nxt   = '0;

        head_top = heading[HEAD_W-1 -: LED_W];
        // Flip the sign bit so heading 0 lands mid-bus and the octants read left-to-right.
        oct_idx  = heading[HEAD_W-1 -: 3] ^ 3'b100;
        led_oct  = '0;
        led_oct[oct_idx] = 1'b1;

        case (state)
            IDLE: begin
                state_nxt = START;
            end
            START: begin
                tmo_nxt   = '0;
                state_nxt = CAL;
            end
            CAL: begin
                tmo_nxt = tmo_cnt + TMO_W'(1);
                led_nxt = blink ? ~CAL_PAT : CAL_PAT;
                // cal_done takes priority over a coincident timeout.
                if (cal_done) begin
                    state_nxt = DISP;
                end else if (tmo_cnt == TMO_W'(CAL_TIMEOUT - 1)) begin
                    if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
                        retry_nxt = retry_cnt + RETRY_W'(1);
                        state_nxt = START;
                    end else begin
                        state_nxt = FAIL;
                    end
                end
            end
            DISP: begin
                if (rdy) begin
                    hold_nxt = head_top;
                end
                case (disp_mode_t'(mode))
                    HEAD:    led_nxt = head_top;
                    HOLD:    led_nxt = hold_reg;
                    OCT:     led_nxt = led_oct;
                    STAT:    led_nxt = LED_W'(retry_cnt);
                    default: led_nxt = '0;
                endcase
                if (recal_req) begin
                    retry_nxt = '0;
                    state_nxt = START;
                end
            end
            FAIL: begin
                led_nxt = blink ? '1 : '0;
                if (recal_req) begin
                    retry_nxt = '0;
                    state_nxt = START;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            retry_cnt <= '0;
            hold_reg  <= '0;
            LED       <= '0;
            strt_cal  <= 1'b0;
            cal_ok    <= 1'b0;
            cal_fail  <= 1'b0;
        end else begin
            state     <= state_nxt;
            tmo_cnt   <= tmo_nxt;
            retry_cnt <= retry_nxt;
            hold_reg  <= hold_nxt;
            LED       <= led_nxt;
            // Status flags track the state being entered so they align with it.
            strt_cal  <= (state_nxt == START);
            cal_ok    <= (state_nxt == DISP);
            cal_fail  <= (state_nxt == FAIL);
        end
    end

endmodule

// File: tb/tb_inert_cal_mon.sv
// Directed bench for inert_cal_mon with CAL_TIMEOUT=16, MAX_RETRY=2, FAST_SIM=1.
module tb_inert_cal_mon;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        cal_done  = 1'b0;
    logic        rdy       = 1'b0;
    logic        recal_req = 1'b0;
    logic [11:0] heading   = 12'h000;
    logic [1:0]  mode      = 2'd0;
    logic        strt_cal;
    logic        cal_ok;
    logic        cal_fail;
    logic [7:0]  LED;

    int errors = 0;
    int checks = 0;
    int cyc;
    int strt_n, strt_first, strt_last, strt_gap;

    inert_cal_mon #(
        .FAST_SIM    (1),
        .LED_W       (8),
        .HEAD_W      (12),
        .CAL_TIMEOUT (16),
        .MAX_RETRY   (2),
        .BLINK_W     (22)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cal_done  (cal_done),
        .rdy       (rdy),
        .heading   (heading),
        .recal_req (recal_req),
        .mode      (mode),
        .strt_cal  (strt_cal),
        .cal_ok    (cal_ok),
        .cal_fail  (cal_fail),
        .LED       (LED)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; a 4-bit prescaler equals cyc mod 16.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and log any strt_cal pulse.
    task automatic step();
        @(negedge clk);
        if (strt_cal === 1'b1) begin
            if (strt_n == 0) strt_first = cyc;
            else             strt_gap   = cyc - strt_last;
            strt_last = cyc;
            strt_n++;
        end
    endtask

    task automatic clr_strt();
        strt_n     = 0;
        strt_first = -1;
        strt_last  = 0;
        strt_gap   = 0;
    endtask

    // LED value registered on the last edge used the prescaler value cyc-1.
    function automatic logic [7:0] exp_blink(input logic [7:0] on_v, input logic [7:0] off_v);
        return (((cyc - 1) % 16) >= 8) ? on_v : off_v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clr_strt();

        // Reset state
        step();
        step();
        chk("rst_led", 32'(LED), 32'h0);
        chk("rst_strt", 32'(strt_cal), 32'h0);
        chk("rst_ok", 32'(cal_ok), 32'h0);
        chk("rst_fail", 32'(cal_fail), 32'h0);

        // Normal calibration, cal_done 5 cycles after strt_cal
        rst = 1'b0;
        step();
        chk("s1_strt_first", 32'(strt_cal), 32'h1);
        step();
        chk("s1_strt_one_cycle", 32'(strt_cal), 32'h0);
        step();
        step();
        chk("s1_cal_led", 32'(LED), 32'(exp_blink(8'h5A, 8'hA5)));
        step();
        step();
        cal_done = 1'b1;
        step();
        cal_done = 1'b0;
        chk("s1_cal_ok", 32'(cal_ok), 32'h1);
        mode    = 2'd0;
        heading = 12'h7F0;
        step();
        chk("s1_led_head", 32'(LED), 32'h7F);
        chk("s1_strt_count", 32'(strt_n), 32'd1);

        // No cal_done: three attempts 17 cycles apart, then failure blink
        rst = 1'b1;
        step();
        step();
        clr_strt();
        rst = 1'b0;
        for (int i = 0; i < 100 && cal_fail !== 1'b1; i++) step();
        chk("s2_fail_reached", 32'(cal_fail), 32'h1);
        chk("s2_strt_count", 32'(strt_n), 32'd3);
        chk("s2_strt_first", 32'(strt_first), 32'd1);
        chk("s2_strt_last", 32'(strt_last), 32'd35);
        chk("s2_strt_gap", 32'(strt_gap), 32'd17);
        chk("s2_fail_cyc", 32'(cyc), 32'd52);
        chk("s2_ok_low", 32'(cal_ok), 32'h0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("s2_fail_led", 32'(LED), 32'(exp_blink(8'hFF, 8'h00)));
            chk("s2_fail_hold", 32'(cal_fail), 32'h1);
        end
        chk("s2_no_more_strt", 32'(strt_n), 32'd3);

        // Recalibrate from FAIL; recal_req during CAL is ignored
        clr_strt();
        recal_req = 1'b1;
        step();
        recal_req = 1'b0;
        chk("s3_recal_strt", 32'(strt_cal), 32'h1);
        chk("s3_fail_clr", 32'(cal_fail), 32'h0);
        step();
        step();
        recal_req = 1'b1;
        step();
        recal_req = 1'b0;
        chk("s3_recal_in_cal_ignored", 32'(strt_cal), 32'h0);
        repeat (14) step();
        chk("s3_retry_strt", 32'(strt_cal), 32'h1);
        chk("s3_strt_count", 32'(strt_n), 32'd2);
        chk("s3_strt_gap", 32'(strt_gap), 32'd17);

        // cal_done exactly on the second attempt's timeout cycle wins
        repeat (16) step();
        cal_done = 1'b1;
        step();
        cal_done = 1'b0;
        chk("s3_tmo_tie_ok", 32'(cal_ok), 32'h1);
        chk("s3_tmo_tie_fail", 32'(cal_fail), 32'h0);
        chk("s3_tmo_tie_strt", 32'(strt_cal), 32'h0);
        mode = 2'd3;
        step();
        chk("s3_mode3_retry", 32'(LED), 32'h01);
        chk("s3_no_third_strt", 32'(strt_n), 32'd2);

        // Hold, live heading and octant display modes
        mode    = 2'd1;
        heading = 12'h340;
        rdy     = 1'b1;
        step();
        rdy     = 1'b0;
        heading = 12'hC00;
        step();
        chk("s4_hold_load", 32'(LED), 32'h34);
        step();
        chk("s4_hold_keep", 32'(LED), 32'h34);
        mode = 2'd0;
        step();
        chk("s4_live_head", 32'(LED), 32'hC0);
        mode    = 2'd2;
        heading = 12'h000;
        step();
        chk("s4_oct_zero", 32'(LED), 32'h10);
        heading = 12'h800;
        step();
        chk("s4_oct_neg", 32'(LED), 32'h01);
        heading = 12'hE00;
        step();
        chk("s4_oct_e00", 32'(LED), 32'h08);

        // Reset asserted mid-CAL
        clr_strt();
        recal_req = 1'b1;
        step();
        recal_req = 1'b0;
        chk("s5_recal_disp_strt", 32'(strt_cal), 32'h1);
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("s5_rst_led_async", 32'(LED), 32'h0);
        chk("s5_rst_strt_async", 32'(strt_cal), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s5_rst_led", 32'(LED), 32'h0);
            chk("s5_rst_strt", 32'(strt_cal), 32'h0);
            chk("s5_rst_ok", 32'(cal_ok), 32'h0);
        end
        clr_strt();
        rst = 1'b0;
        repeat (10) step();
        chk("s5_strt_count", 32'(strt_n), 32'd1);
        chk("s5_strt_first", 32'(strt_first), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
